// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the Y86-64 SEQ decode and write-back stages.
//
// Contents:
//   DEFAULT_DATA_W  default register/data width (64)
//   IHALT..IPOPQ    instruction codes 0..11 (12..15 are illegal)
//   RRSP            register index of %rsp
//   RNONE           register index meaning "no register"
//   isLegalIcode    true for icodes that may commit

package y86_pkg;

    localparam int DEFAULT_DATA_W = 64;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    localparam logic [3:0] RRSP  = 4'd4;
    localparam logic [3:0] RNONE = 4'd15;

    // Codes above IPOPQ are not part of the ISA and must never change state.
    function automatic logic isLegalIcode(input logic [3:0] icode);
        return (icode <= IPOPQ);
    endfunction

endpackage

// File: rtl/wb_dst_sel.sv
// wb_dst_sel: combinational selection of the E and M write destinations
// for the committing instruction.
//
// Ports:
//   icode_i  instruction code
//   rA_i     register field A
//   rB_i     register field B
//   cnd_i    condition result (only meaningful for cmovXX)
//   dstE_o   destination for valE (RNONE = none)
//   dstM_o   destination for valM (RNONE = none)

module wb_dst_sel
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    input  logic [3:0] rA_i,
    input  logic [3:0] rB_i,
    input  logic       cnd_i,
    output logic [3:0] dstE_o,
    output logic [3:0] dstM_o
);

    // E destination: rrmovq doubles as cmovXX, so a failed condition
    // suppresses the write by selecting RNONE. Stack ops update %rsp.
    always_comb begin
        dstE_o = RNONE;
        case (icode_i)
            IRRMOVQ:                     dstE_o = cnd_i ? rB_i : RNONE;
            IIRMOVQ, IOPQ:               dstE_o = rB_i;
            ICALL, IRET, IPUSHQ, IPOPQ:  dstE_o = RRSP;
            default:                     dstE_o = RNONE;
        endcase
    end

    // M destination: only loads from memory (mrmovq, popq) write valM.
    always_comb begin
        dstM_o = RNONE;
        if (icode_i == IMRMOVQ || icode_i == IPOPQ) begin
            dstM_o = rA_i;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: write-back end of the Y86-64 SEQ register file.
// Commits valE/valM to the selected destinations, serves two combinational
// read ports, holds the sticky halt latch and counts retired instructions.
//
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   wb_en            instruction valid for commit this cycle
//   icode, rA, rB    fields of the committing instruction
//   cnd              execute-stage condition (cmovXX)
//   valE, valM       ALU result and memory read data
//   srcA/srcB        read addresses (15 = none, reads 0)
//   valA/valB        read data
//   dstE/dstM        selected destinations
//   halted           sticky, set when halt commits
//   retired          committed-instruction count, wraps
//
// Optional build macro: REGFILE_WB_BYPASS_EN forwards same-cycle write data
// to the read ports (valM before valE before the stored value).

module regfile_writeback
    import y86_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREGS  = 15,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              halted_q;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;
    logic              commit;

    wb_dst_sel u_dst_sel (
        .icode_i (icode),
        .rA_i    (rA),
        .rB_i    (rB),
        .cnd_i   (cnd),
        .dstE_o  (dstE),
        .dstM_o  (dstM)
    );

    // Once halted, nothing else may commit until reset.
    assign commit    = wb_en & ~halted_q & isLegalIcode(icode);
    assign retired_d = retired_q + CNT_W'(1);

    // Register array, halt latch and counter. The valM write is placed
    // after the valE write so it wins when both target the same register
    // (popq %rsp).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else if (commit) begin
            if (dstE != RNONE) begin
                regs_q[dstE] <= valE;
            end
            if (dstM != RNONE) begin
                regs_q[dstM] <= valM;
            end
            retired_q <= retired_d;
            if (icode == IHALT) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Read port: RNONE reads as zero. With forwarding enabled, the value
    // being committed this cycle is returned instead of the stale copy.
    function automatic logic [DATA_W-1:0] readPort(input logic [3:0] src);
        logic [DATA_W-1:0] data;
        data = (src == RNONE) ? '0 : regs_q[src];
`ifdef REGFILE_WB_BYPASS_EN
        if (commit && src != RNONE && src == dstM) begin
            data = valM;
        end else if (commit && src != RNONE && src == dstE) begin
            data = valE;
        end
`endif
        return data;
    endfunction

    always_comb begin
        valA = readPort(srcA);
        valB = readPort(srcB);
    end

    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: self-checking bench for regfile_writeback.
// Expected register contents are queued when an instruction is driven and
// popped/compared once the commit edge has passed.

module tb_regfile_writeback;

    typedef struct {
        string       name;
        logic [3:0]  r;
        logic [63:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [3:0]  icode, rA, rB;
    logic        cnd;
    logic [63:0] valE, valM;
    logic [3:0]  srcA, srcB;
    logic [63:0] valA, valB;
    logic [3:0]  dstE, dstM;
    logic        halted;
    logic [31:0] retired;

    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t expQ[$];
    exp_t e;

    regfile_writeback dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .icode   (icode),
        .rA      (rA),
        .rB      (rB),
        .cnd     (cnd),
        .valE    (valE),
        .valM    (valM),
        .srcA    (srcA),
        .srcB    (srcB),
        .valA    (valA),
        .valB    (valB),
        .dstE    (dstE),
        .dstM    (dstM),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    // Drive one instruction on the falling edge, ahead of the commit edge.
    task automatic driveOp(input logic w, input logic [3:0] ic, input logic [3:0] ra,
                           input logic [3:0] rb, input logic c,
                           input logic [63:0] ve, input logic [63:0] vm);
        @(negedge clk);
        wb_en = w; icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm;
    endtask

    // Let the commit edge pass, then drop wb_en so nothing commits twice.
    task automatic tick();
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        driveOp(1'b0, 4'd1, 4'd15, 4'd15, 1'b0, 64'd0, 64'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        testsRun++;
        if (halted !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_halted got %0b want 0", halted);
        end
        testsRun++;
        if (retired !== 32'd0) begin
            testsFailed++; $display("[TB] FAIL reset_retired got %0d want 0", retired);
        end
        for (int i = 0; i < 16; i++) begin
            srcA = 4'(i);
            #1;
            testsRun++;
            if (valA !== 64'd0) begin
                testsFailed++; $display("[TB] FAIL reset_reg%0d got %h want 0", i, valA);
            end
        end
    endtask

    task automatic test_irmovq();
        driveOp(1'b1, 4'd3, 4'd15, 4'd2, 1'b0, 64'h1234, 64'd0);
        expQ.push_back('{"irmovq_r2", 4'd2, 64'h1234});
        #1;
        testsRun++;
        if (dstE !== 4'd2 || dstM !== 4'd15) begin
            testsFailed++; $display("[TB] FAIL irmovq_dst got E=%0d M=%0d want E=2 M=15", dstE, dstM);
        end
        tick();
        e = expQ.pop_front();
        srcA = e.r;
        #1;
        testsRun++;
        if (valA !== e.v) begin
            testsFailed++; $display("[TB] FAIL %s got %h want %h", e.name, valA, e.v);
        end
        testsRun++;
        if (retired !== 32'd1) begin
            testsFailed++; $display("[TB] FAIL irmovq_retired got %0d want 1", retired);
        end
    endtask

    task automatic test_cmov();
        driveOp(1'b1, 4'd2, 4'd1, 4'd5, 1'b0, 64'h55, 64'd0);
        expQ.push_back('{"cmov_nottaken_r5", 4'd5, 64'h0});
        #1;
        testsRun++;
        if (dstE !== 4'd15) begin
            testsFailed++; $display("[TB] FAIL cmov_nottaken_dstE got %0d want 15", dstE);
        end
        tick();
        e = expQ.pop_front();
        srcB = e.r;
        #1;
        testsRun++;
        if (valB !== e.v) begin
            testsFailed++; $display("[TB] FAIL %s got %h want %h", e.name, valB, e.v);
        end
        testsRun++;
        if (retired !== 32'd2) begin
            testsFailed++; $display("[TB] FAIL cmov_nottaken_retired got %0d want 2", retired);
        end

        driveOp(1'b1, 4'd2, 4'd1, 4'd5, 1'b1, 64'h55, 64'd0);
        expQ.push_back('{"cmov_taken_r5", 4'd5, 64'h55});
        tick();
        e = expQ.pop_front();
        srcB = e.r;
        #1;
        testsRun++;
        if (valB !== e.v) begin
            testsFailed++; $display("[TB] FAIL %s got %h want %h", e.name, valB, e.v);
        end
        testsRun++;
        if (retired !== 32'd3) begin
            testsFailed++; $display("[TB] FAIL cmov_taken_retired got %0d want 3", retired);
        end
    endtask

    task automatic test_popq_rsp();
        driveOp(1'b1, 4'd11, 4'd4, 4'd15, 1'b0, 64'h100, 64'hBEEF);
        expQ.push_back('{"popq_rsp_r4", 4'd4, 64'hBEEF});
        #1;
        testsRun++;
        if (dstE !== 4'd4 || dstM !== 4'd4) begin
            testsFailed++; $display("[TB] FAIL popq_dst got E=%0d M=%0d want E=4 M=4", dstE, dstM);
        end
        tick();
        e = expQ.pop_front();
        srcA = e.r;
        #1;
        testsRun++;
        if (valA !== e.v) begin
            testsFailed++; $display("[TB] FAIL %s got %h want %h", e.name, valA, e.v);
        end
        testsRun++;
        if (retired !== 32'd4) begin
            testsFailed++; $display("[TB] FAIL popq_retired got %0d want 4", retired);
        end
    endtask

    task automatic test_stall_illegal();
        driveOp(1'b0, 4'd6, 4'd15, 4'd3, 1'b0, 64'd9, 64'd0);
        expQ.push_back('{"stall_r3", 4'd3, 64'h0});
        tick();
        driveOp(1'b1, 4'd13, 4'd3, 4'd3, 1'b1, 64'd9, 64'd9);
        expQ.push_back('{"illegal_r3", 4'd3, 64'h0});
        tick();
        srcA = 4'd3;
        #1;
        for (int k = 0; k < 2; k++) begin
            e = expQ.pop_front();
            testsRun++;
            if (valA !== e.v) begin
                testsFailed++; $display("[TB] FAIL %s got %h want %h", e.name, valA, e.v);
            end
        end
        testsRun++;
        if (retired !== 32'd4 || halted !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stall_illegal_state got retired=%0d halted=%0b want 4/0", retired, halted);
        end
    endtask

    task automatic test_collision();
        driveOp(1'b1, 4'd3, 4'd15, 4'd2, 1'b0, 64'h1, 64'd0);
        tick();
        srcA = 4'd2;
        driveOp(1'b1, 4'd6, 4'd15, 4'd2, 1'b0, 64'hA, 64'd0);
`ifdef REGFILE_WB_BYPASS_EN
        expQ.push_back('{"collision_same_cycle", 4'd2, 64'hA});
`else
        expQ.push_back('{"collision_same_cycle", 4'd2, 64'h1});
`endif
        expQ.push_back('{"collision_after_edge", 4'd2, 64'hA});
        #1;
        e = expQ.pop_front();
        testsRun++;
        if (valA !== e.v) begin
            testsFailed++; $display("[TB] FAIL %s got %h want %h", e.name, valA, e.v);
        end
        tick();
        e = expQ.pop_front();
        testsRun++;
        if (valA !== e.v) begin
            testsFailed++; $display("[TB] FAIL %s got %h want %h", e.name, valA, e.v);
        end
        testsRun++;
        if (retired !== 32'd6) begin
            testsFailed++; $display("[TB] FAIL collision_retired got %0d want 6", retired);
        end
    endtask

    task automatic test_halt();
        driveOp(1'b1, 4'd0, 4'd15, 4'd15, 1'b0, 64'd0, 64'd0);
        tick();
        testsRun++;
        if (halted !== 1'b1 || retired !== 32'd7) begin
            testsFailed++;
            $display("[TB] FAIL halt_commit got halted=%0b retired=%0d want 1/7", halted, retired);
        end
        driveOp(1'b1, 4'd3, 4'd15, 4'd1, 1'b0, 64'd7, 64'd0);
        expQ.push_back('{"after_halt_r1", 4'd1, 64'h0});
        tick();
        e = expQ.pop_front();
        srcA = e.r;
        #1;
        testsRun++;
        if (valA !== e.v) begin
            testsFailed++; $display("[TB] FAIL %s got %h want %h", e.name, valA, e.v);
        end
        testsRun++;
        if (retired !== 32'd7 || halted !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL after_halt_state got halted=%0b retired=%0d want 1/7", halted, retired);
        end
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        testsRun++;
        if (halted !== 1'b0 || retired !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL halt_reset got halted=%0b retired=%0d want 0/0", halted, retired);
        end
        srcA = 4'd2; srcB = 4'd4;
        #1;
        testsRun++;
        if (valA !== 64'd0 || valB !== 64'd0) begin
            testsFailed++; $display("[TB] FAIL halt_reset_regs got r2=%h r4=%h want 0/0", valA, valB);
        end
    endtask

    // Random instructions committed on consecutive cycles against a model.
    task automatic test_back_to_back();
        logic [63:0] mRegs [16];
        logic [31:0] mRetired;
        logic [3:0]  ic, ra, rb, dE, dM, rd;
        logic        w, c, doCommit;
        logic [63:0] ve, vm;
        for (int i = 0; i < 16; i++) mRegs[i] = 64'd0;
        mRetired = 32'd0;
        for (int n = 0; n < 40; n++) begin
            ic = 4'($urandom_range(1, 15));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            c  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 3) != 0);
            ve = {$urandom, $urandom};
            vm = {$urandom, $urandom};
            dE = 4'd15;
            dM = 4'd15;
            if (ic == 4'd2 && c) dE = rb;
            if (ic == 4'd3 || ic == 4'd6) dE = rb;
            if (ic >= 4'd8 && ic <= 4'd11) dE = 4'd4;
            if (ic == 4'd5 || ic == 4'd11) dM = ra;
            doCommit = w && (ic <= 4'd11);
            if (doCommit) begin
                if (dE != 4'd15) mRegs[dE] = ve;
                if (dM != 4'd15) mRegs[dM] = vm;
                mRetired = mRetired + 32'd1;
            end
            rd = (dM != 4'd15) ? dM : ((dE != 4'd15) ? dE : rb);
            driveOp(w, ic, ra, rb, c, ve, vm);
            expQ.push_back('{"b2b_read", rd, mRegs[rd]});
            tick();
            e = expQ.pop_front();
            srcB = e.r;
            #1;
            testsRun++;
            if (valB !== e.v || retired !== mRetired) begin
                testsFailed++;
                $display("[TB] FAIL %s%0d r%0d got %h cnt %0d want %h cnt %0d",
                         e.name, n, e.r, valB, retired, e.v, mRetired);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; wb_en = 1'b0; icode = 4'd1; rA = 4'd15; rB = 4'd15;
        cnd = 1'b0; valE = '0; valM = '0; srcA = 4'd15; srcB = 4'd15;
        test_reset();
        test_irmovq();
        test_cmov();
        test_popq_rsp();
        test_stall_illegal();
        test_collision();
        test_halt();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-back end of the Y86-64 SEQ register file; the counterpart of the decode-side source selection.
- Selects the destinations dstE and dstM from icode, rA, rB and cnd, and commits valE and valM on the clock edge.
- Serves the two combinational read ports (srcA/srcB → valA/valB) that decode drives.
- Also owns the halt latch and the retired-instruction counter.

Parameters:
- DATA_W, 64, register and data width.
- NREGS, 15, architectural registers 0..14; index 15 (RNONE) means "no register".
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- wb_en  in  1  instruction valid for commit this cycle; 0 means stall/bubble, no state change.
- icode  in  4  instruction code of the committing instruction.
- rA  in  4  register field A.
- rB  in  4  register field B.
- cnd  in  1  condition result from execute, used by cmovXX.
- valE  in  DATA_W  ALU result.
- valM  in  DATA_W  memory read data.
- srcA  in  4  read address A (15 = none).
- srcB  in  4  read address B (15 = none).
- valA  out  DATA_W  read data A.
- valB  out  DATA_W  read data B.
- dstE  out  4  selected E destination (combinational).
- dstM  out  4  selected M destination (combinational).
- halted  out  1  sticky; set when halt commits.
- retired  out  CNT_W  count of committed instructions.

Behaviour:
- Destination decode (pure combinational from icode/rA/rB/cnd):
  - dstE: icode 2 → rB if cnd else 15; icode 3, 6 → rB; icode 8, 9, 10, 11 → 4 (%rsp); all others → 15.
  - dstM: icode 5, 11 → rA; all others → 15.
- Commit condition: commit = wb_en & ~halted & (icode is 0..11).
  - icode 12..15 is illegal: no register write, no count; halted is unaffected.
- On a rising edge with commit:
  - regs[dstE] ← valE when dstE != 15.
  - regs[dstM] ← valM when dstM != 15.
  - Same destination (dstE == dstM, e.g. popq %rsp): the valM write wins.
- retired increments by 1 per commit (including halt and nop) and wraps modulo 2^CNT_W.
- Halt: icode 0 with commit sets halted = 1 at that edge.
  - halted stays 1 until reset; every later wb_en is ignored.
- Reads: valA = regs[srcA] and valB = regs[srcB], combinational. Address 15 reads 0.
  - Without the optional feature, a read of a register being written in the same cycle returns the old value. The new value is visible after the edge.
- Reset: when rst_n = 0 at a rising edge, all regs, halted and retired clear to 0 on that edge. Reset overrides a simultaneous commit.
  - Reset mid-stream just restarts; no partial writes persist from the reset cycle.
- Latency: one cycle from commit to visibility through the read ports.

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- When defined: the read ports forward same-cycle write data, in priority order:
  1. srcX == dstM (≠ 15) and commit → valM;
  2. else srcX == dstE (≠ 15) and commit → valE;
  3. else regs[srcX].
- When undefined: no forwarding; old value is returned as described above.

Decomposition:
- Shared package y86_pkg: icode constants (IHALT=0 … IPOPQ=11), RRSP=4, RNONE=15, DATA_W default.
  - The decode-side selector uses the same constants.
- One natural sub-module: wb_dst_sel (combinational dstE/dstM decode). Register array, halt latch and counter stay in the top module.

Test Plan:
- Reset, then wb_en=1, icode=3, rB=2, valE=0x1234 → after edge regs[2]=0x1234 via srcA=2; retired=1.
- icode=2, rA=1, rB=5, cnd=0, valE=0x55 → regs[5] unchanged, dstE=15, retired increments; repeat with cnd=1 → regs[5]=0x55.
- popq %rsp: icode=11, rA=4, valE=0x100, valM=0xBEEF → regs[4]=0xBEEF (M wins).
- icode=0 commit → halted=1. A subsequent icode=3, rB=1, valE=7 with wb_en=1 → regs[1] unchanged, retired frozen. Then rst_n=0 for one edge → halted=0, retired=0, all regs 0.
- wb_en=0 with icode=6, rB=3, valE=9 → no write, no count. Illegal icode=13 with wb_en=1 → no write, no count.
- Read/write collision srcA=2, icode=6, rB=2, valE=0xA, old regs[2]=0x1:
  - without REGFILE_WB_BYPASS_EN → valA=0x1 before the edge, 0xA after;
  - with the macro → valA=0xA in the same cycle.
